// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one UART transmitter between N byte-stream
//   requesters. The winner keeps the grant for a whole message, which ends
//   with the byte flagged by req_last. Bytes from different sources therefore
//   never interleave on the serial line. The block drives the transmitter's
//   byte/write handshake and watches its busy flag. If the transmitter never
//   accepts a byte, the block gives up after TIMEOUT cycles.
//
// Parameters:
//   N        number of requesters (2..8)
//   TIMEOUT  clk cycles allowed for tx_busy to rise after tx_wr asserts
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   reset        in   asynchronous, active-low reset
//   req_valid    in   [N]    requester i presents a byte
//   req_data     in   [8N]   byte of requester i in bits [8i+7:8i]
//   req_last     in   [N]    presented byte ends requester i's message
//   req_ack      out  [N]    one-cycle pulse: byte of requester i taken
//   grant        out  [N]    one-hot current owner, 0 when no owner
//   tx_data      out  [8]    byte to transmitter data_in
//   tx_wr        out         to transmitter data_in_wr
//   tx_busy      in          from transmitter busy_tx
//   timeout_err  out         one-cycle pulse: transmitter never took a byte
//   idle         out         high only while in IDLE
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ack,
  output logic [N-1:0]   grant,
  output logic [7:0]     tx_data,
  output logic           tx_wr,
  input  logic           tx_busy,
  output logic           timeout_err,
  output logic           idle
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [IW-1:0] PTR_INIT = IW'(N - 1);

  // State and registered outputs
  logic [1:0]    state_reg, state_next;
  logic [N-1:0]  grant_reg, grant_next;
  logic [IW-1:0] owner_reg, owner_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [N-1:0]  ack_reg, ack_next;
  logic [7:0]    data_reg, data_next;
  logic          wr_reg, wr_next;
  logic          terr_reg, terr_next;
  logic          idle_reg, idle_next;
  logic          last_reg, last_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  // Per-requester byte view of the packed data bus
  logic [7:0] req_byte [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_byte
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Round-robin pick: the first valid requester found scanning from ptr+1
  // upward and wrapping. The scan ends at ptr itself, so the last owner
  // has the lowest priority.
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [IW:0]   cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, ptr_reg} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!sel_found && req_valid[cand[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    ack_next   = '0;
    data_next  = data_reg;
    wr_next    = wr_reg;
    terr_next  = 1'b0;
    last_next  = last_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (sel_found) begin
          grant_next          = '0;
          grant_next[sel_idx] = 1'b1;
          owner_next          = sel_idx;
          state_next          = ST_LOAD;
        end
      end

      // The lock is held here even while the owner has nothing to offer.
      // A message is never split by another source.
      ST_LOAD: begin
        if (req_valid[owner_reg]) begin
          data_next           = req_byte[owner_reg];
          last_next           = req_last[owner_reg];
          ack_next[owner_reg] = 1'b1;
          wr_next             = 1'b1;
          cnt_next            = '0;
          state_next          = ST_WR;
        end
      end

      // Busy is checked before the counter. A transmitter that accepts the
      // byte on the final allowed cycle still counts as a success.
      ST_WR: begin
        if (tx_busy) begin
          wr_next    = 1'b0;
          state_next = ST_SEND;
        end else if (cnt_reg == CNT_LAST) begin
          wr_next    = 1'b0;
          terr_next  = 1'b1;
          grant_next = '0;
          ptr_next   = owner_reg;
          state_next = ST_IDLE;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      ST_SEND: begin
        if (!tx_busy) begin
          if (last_reg) begin
            grant_next = '0;
            ptr_next   = owner_reg;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        wr_next    = 1'b0;
      end
    endcase

    idle_next = (state_next == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      owner_reg <= '0;
      ptr_reg   <= PTR_INIT;
      ack_reg   <= '0;
      data_reg  <= 8'h00;
      wr_reg    <= 1'b0;
      terr_reg  <= 1'b0;
      idle_reg  <= 1'b1;
      last_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      ack_reg   <= ack_next;
      data_reg  <= data_next;
      wr_reg    <= wr_next;
      terr_reg  <= terr_next;
      idle_reg  <= idle_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign grant       = grant_reg;
  assign req_ack     = ack_reg;
  assign tx_data     = data_reg;
  assign tx_wr       = wr_reg;
  assign timeout_err = terr_reg;
  assign idle        = idle_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with N=4. The main instance talks to a
// behavioural transmitter. Its busy flag rises busy_dly+1 samples after
// tx_wr is first seen high and stays up for busy_len cycles. A second
// instance has TIMEOUT=16 and its tx_busy tied low. It shares the requester
// inputs and exercises the give-up path.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        timeout_err;
  logic        idle;

  logic [3:0]  to_req_ack;
  logic [3:0]  to_grant;
  logic [7:0]  to_tx_data;
  logic        to_tx_wr;
  logic        to_tx_busy;
  logic        to_timeout_err;
  logic        to_idle;

  uart_tx_arbiter #(.N(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ack     (req_ack),
    .grant       (grant),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_busy     (tx_busy),
    .timeout_err (timeout_err),
    .idle        (idle)
  );

  uart_tx_arbiter #(.N(4), .TIMEOUT(16)) dut_to (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ack     (to_req_ack),
    .grant       (to_grant),
    .tx_data     (to_tx_data),
    .tx_wr       (to_tx_wr),
    .tx_busy     (to_tx_busy),
    .timeout_err (to_timeout_err),
    .idle        (to_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Requester model state
  int         rq_left   [4];
  int         rq_pos    [4];
  int         rq_msglen [4];
  logic [7:0] rq_byte   [4];
  logic [7:0] rq_step   [4];
  logic       rq_hold   [4];

  // Transmitter model state
  int busy_dly;
  int busy_len;
  int wr_seen;
  int busy_cnt;

  // Monitors
  int         cyc;
  int         busy_fall_cyc;
  int         wr_hi;
  int         to_wr_hi;
  int         to_terr_cnt;
  int         ack_src  [$];
  logic [7:0] ack_data [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]      = (rq_left[i] != 0) && !rq_hold[i];
      req_data[8*i +: 8] = rq_byte[i];
      req_last[i]       = (rq_pos[i] == rq_msglen[i] - 1);
    end
  endtask

  // One clock cycle: sample just after the edge, update the models, re-drive.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_busy) begin
      busy_cnt++;
      if (busy_cnt >= busy_len) begin
        tx_busy       = 1'b0;
        busy_fall_cyc = cyc;
      end
    end else if (tx_wr) begin
      wr_seen++;
      if (wr_seen > busy_dly) begin
        tx_busy  = 1'b1;
        busy_cnt = 0;
        wr_seen  = 0;
      end
    end else begin
      wr_seen = 0;
    end
    if (tx_wr) wr_hi++;
    if (to_tx_wr) to_wr_hi++;
    if (to_timeout_err) to_terr_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (req_ack[i]) begin
        ack_src.push_back(i);
        ack_data.push_back(tx_data);
        $display("txn: cycle %0d requester %0d byte %02h", cyc, i, tx_data);
        if (rq_left[i] > 0) rq_left[i]--;
        rq_pos[i]  = (rq_pos[i] + 1) % rq_msglen[i];
        rq_byte[i] = rq_byte[i] + rq_step[i];
      end
    end
    drive_reqs();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin
      rq_left[i]   = 0;
      rq_pos[i]    = 0;
      rq_msglen[i] = 1;
      rq_byte[i]   = 8'h00;
      rq_step[i]   = 8'h00;
      rq_hold[i]   = 1'b0;
    end
    drive_reqs();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    tx_busy  = 1'b0;
    wr_seen  = 0;
    busy_cnt = 0;
    @(posedge clk);
    #1;
    reset       = 1'b1;
    wr_hi       = 0;
    to_wr_hi    = 0;
    to_terr_cnt = 0;
    ack_src.delete();
    ack_data.delete();
  endtask

  initial begin
    int n;
    int svc;
    int exp_src;
    reset      = 1'b0;
    tx_busy    = 1'b0;
    to_tx_busy = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    busy_dly   = 7;
    busy_len   = 100;
    wr_seen    = 0;
    busy_cnt   = 0;
    cyc        = 0;
    busy_fall_cyc = 0;
    wr_hi = 0;
    to_wr_hi = 0;
    to_terr_cnt = 0;

    // Reset values
    #12;
    check("rst_idle", idle, 1);
    check("rst_grant", grant, 0);
    check("rst_ack", req_ack, 0);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_terr", timeout_err, 0);

    // Single byte from requester 0
    do_reset();
    busy_dly = 7;
    busy_len = 100;
    rq_left[0] = 1;
    rq_byte[0] = 8'hA5;
    drive_reqs();
    tick();
    check("t1_grant", grant, 4'b0001);
    check("t1_idle_low", idle, 0);
    check("t1_no_ack_yet", req_ack, 0);
    tick();
    check("t1_ack", req_ack, 4'b0001);
    check("t1_tx_wr", tx_wr, 1);
    check("t1_tx_data", tx_data, 8'hA5);
    n = 0;
    while (!idle && n < 300) begin
      tick();
      n++;
    end
    check("t1_idle_back", idle, 1);
    check("t1_wr_cycles", wr_hi, 8);
    check("t1_idle_after_fall", cyc - busy_fall_cyc, 1);
    check("t1_ack_count", ack_src.size(), 1);

    // All four continuously valid, single-byte messages
    do_reset();
    busy_dly = 2;
    busy_len = 5;
    for (int i = 0; i < 4; i++) begin
      rq_left[i] = -1;
      rq_byte[i] = 8'h10 + 8'(i);
    end
    drive_reqs();
    n = 0;
    while (ack_src.size() < 8 && n < 500) begin
      tick();
      n++;
    end
    check("t2_count", ack_src.size() >= 8, 1);
    svc = (ack_src.size() < 8) ? ack_src.size() : 8;
    for (int j = 0; j < svc; j++) begin
      exp_src = j % 4;
      check($sformatf("t2_src%0d", j), ack_src[j], exp_src);
      check($sformatf("t2_data%0d", j), ack_data[j], 8'h10 + 8'(exp_src));
    end

    // Requester 2 three-byte message with requester 0 waiting
    do_reset();
    busy_dly = 2;
    busy_len = 5;
    rq_left[2]   = 3;
    rq_msglen[2] = 3;
    rq_byte[2]   = 8'h01;
    rq_step[2]   = 8'h01;
    drive_reqs();
    tick();
    check("t3_grant2", grant, 4'b0100);
    rq_left[0] = 1;
    rq_byte[0] = 8'h55;
    drive_reqs();
    n = 0;
    while (ack_src.size() < 4 && n < 300) begin
      tick();
      n++;
    end
    check("t3_count", ack_src.size(), 4);
    if (ack_src.size() == 4) begin
      check("t3_src0", ack_src[0], 2);
      check("t3_src1", ack_src[1], 2);
      check("t3_src2", ack_src[2], 2);
      check("t3_src3", ack_src[3], 0);
      check("t3_data0", ack_data[0], 8'h01);
      check("t3_data1", ack_data[1], 8'h02);
      check("t3_data2", ack_data[2], 8'h03);
      check("t3_data3", ack_data[3], 8'h55);
    end

    // Timeout instance: transmitter never goes busy
    do_reset();
    busy_dly = 2;
    busy_len = 5;
    rq_left[1] = 1;
    rq_byte[1] = 8'h77;
    drive_reqs();
    tick();
    tick();
    check("t4_tx_data", to_tx_data, 8'h77);
    n = 0;
    while (!to_timeout_err && n < 100) begin
      tick();
      n++;
    end
    check("t4_terr", to_timeout_err, 1);
    check("t4_grant0", to_grant, 0);
    check("t4_idle", to_idle, 1);
    check("t4_tx_wr_low", to_tx_wr, 0);
    check("t4_wr_cycles", to_wr_hi, 16);
    tick();
    check("t4_terr_pulse", to_timeout_err, 0);
    check("t4_terr_count", to_terr_cnt, 1);
    rq_left[0] = 1;
    rq_byte[0] = 8'h40;
    rq_left[2] = 1;
    rq_byte[2] = 8'h42;
    drive_reqs();
    tick();
    check("t4_next_grant", to_grant, 4'b0100);

    // Asynchronous reset during WR of requester 1
    do_reset();
    busy_dly = 7;
    busy_len = 20;
    rq_left[1] = 1;
    rq_byte[1] = 8'h99;
    drive_reqs();
    tick();
    tick();
    check("t5_in_wr", tx_wr, 1);
    check("t5_ack", req_ack, 4'b0010);
    #2;
    reset = 1'b0;
    #1;
    check("t5_tx_wr_async", tx_wr, 0);
    check("t5_grant_async", grant, 0);
    check("t5_ack_async", req_ack, 0);
    check("t5_idle_async", idle, 1);
    rq_left[0] = 1;
    rq_byte[0] = 8'h0A;
    rq_left[1] = 1;
    drive_reqs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("t5_grant_after", grant, 4'b0001);

    // Owner pauses mid-message
    do_reset();
    busy_dly = 2;
    busy_len = 5;
    rq_left[3]   = 2;
    rq_msglen[3] = 2;
    rq_byte[3]   = 8'h30;
    rq_step[3]   = 8'h01;
    drive_reqs();
    tick();
    tick();
    check("t6_ack_first", req_ack, 4'b1000);
    rq_hold[3] = 1'b1;
    drive_reqs();
    for (int j = 0; j < 15; j++) tick();
    wr_hi = 0;
    ack_src.delete();
    ack_data.delete();
    rq_left[1] = 1;
    rq_byte[1] = 8'h11;
    drive_reqs();
    for (int j = 0; j < 50; j++) tick();
    check("t6_no_wr", wr_hi, 0);
    check("t6_no_ack", ack_src.size(), 0);
    check("t6_grant_held", grant, 4'b1000);
    rq_hold[3] = 1'b0;
    drive_reqs();
    tick();
    check("t6_resume_ack", req_ack, 4'b1000);
    check("t6_resume_data", tx_data, 8'h31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
